// File: rtl/soc_hex_pkg.sv
// -----------------------------------------------------------------------------
// soc_hex_pkg
// Shared definitions for the HEX display controller:
//   - Avalon word addresses of the register map
//   - segment width / "all dark" pattern (segments are active-low)
//   - 16-entry hex glyph table plus a lookup helper
// -----------------------------------------------------------------------------
package soc_hex_pkg;

  localparam logic [3:0] ADDR_NIBBLE       = 4'd0;
  localparam logic [3:0] ADDR_DECODE       = 4'd1;
  localparam logic [3:0] ADDR_BLANK        = 4'd2;
  localparam logic [3:0] ADDR_BLINK_MASK   = 4'd3;
  localparam logic [3:0] ADDR_BLINK_PERIOD = 4'd4;
  localparam logic [3:0] ADDR_RAW_BASE     = 4'd8;

  localparam int              SEG_W   = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low glyphs, bit 0 = segment a. Entry for nibble n sits at
  // bits [7n+6:7n], so the list below reads F (MSBs) down to 0 (LSBs).
  localparam logic [16*SEG_W-1:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
    return HEX_GLYPHS[int'(nib)*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/soc_hex_seg_decoder.sv
// -----------------------------------------------------------------------------
// soc_hex_seg_decoder
// Combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nibble_i  in  4  hex value 0..F
//   seg_o     out 7  segments, bit 0 = a, 0 = lit
// -----------------------------------------------------------------------------
module soc_hex_seg_decoder
  import soc_hex_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = hex_glyph(nibble_i);

endmodule

// File: rtl/soc_hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// soc_hex_display_ctrl
// Avalon-MM slave driving NUM_DIGITS active-low 7-segment displays. Each digit
// shows either a decoded nibble or a raw segment pattern, with per-digit
// blanking and an optional blink prescaler.
//
// Build option: define HEX_DISP_BLINK_EN to include BLINK_MASK (addr 3),
// BLINK_PERIOD (addr 4) and the prescaler. Without it those addresses read 0,
// ignore writes, and no digit ever blinks.
//
// Ports:
//   clk         in  1             system clock
//   reset_n     in  1             asynchronous active-low reset
//   address     in  4             Avalon word address
//   chipselect  in  1             slave select
//   write_n     in  1             active-low write strobe
//   writedata   in  32            write data
//   readdata    out 32            combinational read data, zero wait states
//   out_port    out 7*NUM_DIGITS  registered segments, digit i at [7i+6:7i]
// -----------------------------------------------------------------------------
module soc_hex_display_ctrl
  import soc_hex_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int BLINK_CNT_W = 26
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [SEG_W*NUM_DIGITS-1:0] out_port
);

  localparam int NIB_W = 4 * NUM_DIGITS;

  logic wr_en;
  assign wr_en = chipselect & ~write_n;

  // Upper writedata bits only matter for some registers/configurations.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  logic [NIB_W-1:0]                        nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]                   decode_q, decode_d;
  logic [NUM_DIGITS-1:0]                   blank_q,  blank_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]        raw_q,    raw_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]        glyph;
  logic [SEG_W*NUM_DIGITS-1:0]             out_q,    out_d;
  logic [NUM_DIGITS-1:0]                   blink_off;

  // ---------------------------------------------------------------------------
  // Control register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble_d = nibble_q;
    decode_d = decode_q;
    blank_d  = blank_q;
    if (wr_en) begin
      case (address)
        ADDR_NIBBLE: nibble_d = writedata[NIB_W-1:0];
        ADDR_DECODE: decode_d = writedata[NUM_DIGITS-1:0];
        ADDR_BLANK:  blank_d  = writedata[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

`ifdef HEX_DISP_BLINK_EN
  // ---------------------------------------------------------------------------
  // Blink prescaler: counter runs BLINK_PERIOD..0, toggling phase on each
  // reload, so one phase lasts BLINK_PERIOD+1 cycles. A period of 0 parks the
  // prescaler with phase 0 so masked digits stay visible.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0]  blink_mask_q, blink_mask_d;
  logic [BLINK_CNT_W-1:0] period_q, period_d;
  logic [BLINK_CNT_W-1:0] cnt_q, cnt_d;
  logic                   phase_q, phase_d;

  always_comb begin
    blink_mask_d = blink_mask_q;
    period_d     = period_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;

    if (wr_en && address == ADDR_BLINK_MASK) begin
      blink_mask_d = writedata[NUM_DIGITS-1:0];
    end

    if (wr_en && address == ADDR_BLINK_PERIOD) begin
      // Restart the blink cycle cleanly from the lit phase.
      period_d = writedata[BLINK_CNT_W-1:0];
      cnt_d    = writedata[BLINK_CNT_W-1:0];
      phase_d  = 1'b0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - BLINK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_q <= '0;
      period_q     <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
    end else begin
      blink_mask_q <= blink_mask_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
    end
  end

  // Uses next-state values so out_port tracks the registers with no extra lag.
  assign blink_off = blink_mask_d & {NUM_DIGITS{phase_d}};
`else
  assign blink_off = '0;
`endif

  // ---------------------------------------------------------------------------
  // Per-digit raw registers, decoders and output selection. The output mux is
  // fed from next-state values so a write lands on out_port one cycle later.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [3:0] RAW_ADDR = ADDR_RAW_BASE + 4'(gi);

      assign raw_d[gi] = (wr_en && address == RAW_ADDR) ? writedata[SEG_W-1:0]
                                                        : raw_q[gi];

      soc_hex_seg_decoder u_dec (
        .nibble_i (nibble_d[4*gi +: 4]),
        .seg_o    (glyph[gi])
      );

      assign out_d[SEG_W*gi +: SEG_W] = blank_d[gi]   ? SEG_OFF   :
                                        blink_off[gi] ? SEG_OFF   :
                                        decode_d[gi]  ? glyph[gi] :
                                                        raw_d[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nibble_q <= '0;
      decode_q <= '0;
      blank_q  <= '0;
      raw_q    <= {NUM_DIGITS{SEG_OFF}};
      out_q    <= '1;
    end else begin
      nibble_q <= nibble_d;
      decode_q <= decode_d;
      blank_q  <= blank_d;
      raw_q    <= raw_d;
      out_q    <= out_d;
    end
  end

  assign out_port = out_q;

  // ---------------------------------------------------------------------------
  // Read mux from current register contents (old value during a write).
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_NIBBLE:       readdata[NIB_W-1:0]      = nibble_q;
      ADDR_DECODE:       readdata[NUM_DIGITS-1:0] = decode_q;
      ADDR_BLANK:        readdata[NUM_DIGITS-1:0] = blank_q;
`ifdef HEX_DISP_BLINK_EN
      ADDR_BLINK_MASK:   readdata[NUM_DIGITS-1:0] = blink_mask_q;
      ADDR_BLINK_PERIOD: readdata[BLINK_CNT_W-1:0] = period_q;
`endif
      default: ;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == ADDR_RAW_BASE + 4'(i)) begin
        readdata[SEG_W-1:0] = raw_q[i];
      end
    end
  end

endmodule
